// File: rtl/covid_pio_in_edge_if.sv
// covid_pio_in_edge_if
//   Avalon-MM slave bus for the PIO edge-capture block.
//   master : drives address, chipselect, write_n and writedata; receives readdata.
//   slave  : receives address, chipselect, write_n and writedata; drives readdata.
interface covid_pio_in_edge_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/covid_pio_in_edge.sv
// covid_pio_in_edge
//   Parallel input port with per-bit edge capture and a level interrupt.
//   Register map (word address):
//     0 data          (RO, current sampled pins)
//     1 reserved      (reads 0, writes ignored)
//     2 irq_mask      (RW)
//     3 edge_capture  (read, write 1 to clear)
//   Ports:
//     clk     : single clock
//     reset   : asynchronous active-high reset
//     bus     : Avalon slave (covid_pio_in_edge_if.slave)
//     in_port : external pins, asynchronous to clk
//     irq     : active-high level interrupt, registered
//   Parameters:
//     WIDTH     : pin count, 1..32
//     EDGE_TYPE : 0 rising, 1 falling, 2 any edge
//   Build option:
//     COVID_PIO_IN_SYNC_EN : adds a 2-flop synchroniser ahead of s1
//                            (2 extra clk of latency on data and irq).
module covid_pio_in_edge #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  covid_pio_in_edge_if.slave   bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  logic [WIDTH-1:0] sample_in;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] detect;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_en;
  logic             mask_wr;
  logic [31:0]      rd_mux;

`ifdef COVID_PIO_IN_SYNC_EN
  logic [WIDTH-1:0] sync_0;
  logic [WIDTH-1:0] sync_1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_0 <= '0;
      sync_1 <= '0;
    end else begin
      sync_0 <= in_port;
      sync_1 <= sync_0;
    end
  end

  assign sample_in = sync_1;
`else
  assign sample_in = in_port;
`endif

  // Writedata bits above WIDTH are ignored by design.
  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata;
      assign unused_wdata = ^bus.writedata[31:WIDTH];
    end
  endgenerate

  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign detect = rise;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign detect = fall;
    end else begin : g_any
      assign detect = rise | fall;
    end
  endgenerate

  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign mask_wr = wr_en && (bus.address == 2'd2);
  assign cap_clr = (wr_en && (bus.address == 2'd3)) ? bus.writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux[WIDTH-1:0] = s1;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1           <= '0;
      s2           <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      s1 <= sample_in;
      s2 <= s1;
      if (mask_wr) begin
        irq_mask <= bus.writedata[WIDTH-1:0];
      end
      // Clear first, then OR in new edges so a same-cycle set wins.
      edge_capture <= (edge_capture & ~cap_clr) | detect;
      bus.readdata <= rd_mux;
      irq          <= |(edge_capture & irq_mask);
    end
  end

endmodule

// File: tb/tb_covid_pio_in_edge.sv
module tb_covid_pio_in_edge;

`ifdef COVID_PIO_IN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam int SEL_R = 0;
  localparam int SEL_F = 1;
  localparam int SEL_A = 2;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_r;
  logic [7:0]  in_f;
  logic        irq_r;
  logic        irq_f;
  logic        irq_a;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    int          sel;
  } exp_t;

  exp_t sb[$];

  covid_pio_in_edge_if bus_r ();
  covid_pio_in_edge_if bus_f ();
  covid_pio_in_edge_if bus_a ();

  assign bus_r.address = address;  assign bus_r.chipselect = chipselect;
  assign bus_r.write_n = write_n;  assign bus_r.writedata  = writedata;
  assign bus_f.address = address;  assign bus_f.chipselect = chipselect;
  assign bus_f.write_n = write_n;  assign bus_f.writedata  = writedata;
  assign bus_a.address = address;  assign bus_a.chipselect = chipselect;
  assign bus_a.write_n = write_n;  assign bus_a.writedata  = writedata;

  covid_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset(reset), .bus(bus_r.slave), .in_port(in_r), .irq(irq_r));
  covid_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset(reset), .bus(bus_f.slave), .in_port(in_f), .irq(irq_f));
  covid_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset(reset), .bus(bus_a.slave), .in_port(in_r), .irq(irq_a));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input int sel, input logic [1:0] a, input logic [31:0] e, input string tag);
    exp_t        ent;
    logic [31:0] obs;
    address = a;
    sb.push_back('{tag: tag, exp: e, sel: sel});
    tick();
    ent = sb.pop_front();
    case (ent.sel)
      SEL_R:   obs = bus_r.readdata;
      SEL_F:   obs = bus_f.readdata;
      default: obs = bus_a.readdata;
    endcase
    chk(ent.tag, obs, ent.exp);
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_r       = 8'h00;
    in_f       = 8'hFF;
    @(negedge clk);
    chk("reset_irq_r", {31'd0, irq_r}, 32'd0);
    chk("reset_rdata_r", bus_r.readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 3) tick();

    rd(SEL_R, 2'd2, 32'h0, "reset_mask");
    rd(SEL_R, 2'd3, 32'h0, "reset_capture");
    rd(SEL_F, 2'd3, 32'h0, "fall_no_rise_capture");

    // Rising edges 0x00 -> 0x05 with full mask.
    wr(2'd2, 32'hFFFF_FFFF);
    address = 2'd0;
    in_r    = 8'h05;
    repeat (LAT + 1) tick();
    chk("data_early", bus_r.readdata, 32'h0);
    tick();
    chk("data_05", bus_r.readdata, 32'h05);
    chk("irq_r_early", {31'd0, irq_r}, 32'd0);
    tick();
    chk("irq_r_set", {31'd0, irq_r}, 32'd1);
    rd(SEL_R, 2'd3, 32'h05, "rise_capture_05");
    rd(SEL_A, 2'd3, 32'h05, "any_capture_05");
    rd(SEL_R, 2'd0, 32'h05, "rise_data_05");

    // Falling transitions: only the any-edge instance captures them.
    wr(2'd3, 32'hFF);
    in_r = 8'h00;
    repeat (LAT + 3) tick();
    rd(SEL_A, 2'd3, 32'h05, "any_capture_fall");
    rd(SEL_R, 2'd3, 32'h00, "rise_ignores_fall");

    // Falling-edge instance.
    in_f = 8'hF0;
    repeat (LAT + 3) tick();
    rd(SEL_F, 2'd3, 32'h0F, "fall_capture_0f");
    chk("irq_f_set", {31'd0, irq_f}, 32'd1);
    in_f = 8'hFF;
    repeat (LAT + 3) tick();
    rd(SEL_F, 2'd3, 32'h0F, "fall_ignores_rise");

    // Write-1-to-clear, then clear colliding with a new bit-2 edge.
    wr(2'd3, 32'h03);
    rd(SEL_F, 2'd3, 32'h0C, "clear_03");
    in_f = 8'hFB;
    repeat (LAT + 1) tick();
    wr(2'd3, 32'h0C);
    rd(SEL_F, 2'd3, 32'h04, "set_wins_clear");

    // Reserved and data writes are ignored; upper read bits are 0.
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'hFFFF_FFFF);
    rd(SEL_F, 2'd1, 32'h0, "reserved_reads_0");
    rd(SEL_F, 2'd2, 32'hFF, "mask_kept_ff");

    // Mask gating of irq.
    wr(2'd3, 32'hFF);
    wr(2'd2, 32'h00);
    in_r = 8'h80;
    repeat (LAT + 3) tick();
    chk("irq_masked", {31'd0, irq_r}, 32'd0);
    rd(SEL_R, 2'd3, 32'h80, "capture_80");
    wr(2'd2, 32'h80);
    tick();
    chk("irq_unmasked", {31'd0, irq_r}, 32'd1);
    wr(2'd3, 32'h80);
    tick();
    chk("irq_cleared", {31'd0, irq_r}, 32'd0);

    // Asynchronous reset mid-write.
    wr(2'd2, 32'hFF);
    in_r = 8'hBC;
    repeat (LAT + 3) tick();
    rd(SEL_R, 2'd3, 32'h3C, "capture_3c");
    chk("irq_pre_reset", {31'd0, irq_r}, 32'd1);
    address    = 2'd2;
    writedata  = 32'hFF;
    chipselect = 1'b1;
    write_n    = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_irq", {31'd0, irq_r}, 32'd0);
    chk("async_rdata", bus_r.readdata, 32'h0);
    in_r = 8'h01;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    reset      = 1'b0;
    rd(SEL_R, 2'd2, 32'h0, "write_discarded");
    repeat (LAT + 3) tick();
    rd(SEL_R, 2'd3, 32'h01, "post_reset_rise");
    chk("post_reset_irq", {31'd0, irq_r}, 32'd0);

    // Latency of data and irq on a 0x00 -> 0xAA step.
    wr(2'd2, 32'hFF);
    in_r = 8'h00;
    repeat (LAT + 3) tick();
    wr(2'd3, 32'hFF);
    address = 2'd0;
    in_r    = 8'hAA;
    repeat (LAT + 1) tick();
    chk("aa_data_early", bus_r.readdata, 32'h0);
    tick();
    chk("aa_data", bus_r.readdata, 32'hAA);
    chk("aa_irq_early", {31'd0, irq_r}, 32'd0);
    tick();
    chk("aa_irq", {31'd0, irq_r}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/covid_pio_in_edge.md
COVID_PIO_IN_EDGE -- requirements
Module: covid_pio_in_edge

Interface
- REQ-001: Parameter WIDTH, default 8: input port width, legal range 1..32.
- REQ-002: Parameter EDGE_TYPE, default 0: 0 = rising, 1 = falling, 2 = any edge captured.
- REQ-003: clk  input  1  single clock for all logic.
- REQ-004: reset  input  1  asynchronous, active-high reset.
- REQ-005: address  input  2  Avalon slave word address.
- REQ-006: chipselect  input  1  Avalon slave select.
- REQ-007: write_n  input  1  active-low write strobe, qualified by chipselect.
- REQ-008: writedata  input  32  write data; bits above WIDTH ignored.
- REQ-009: in_port  input  WIDTH  external input pins, asynchronous to clk.
- REQ-010: readdata  output  32  registered read data; bits above WIDTH read 0.
- REQ-011: irq  output  1  active-high level interrupt.

Function
- REQ-012: The register map SHALL be: 0 = data (RO), 1 = reserved (reads 0, writes ignored), 2 = irq_mask (RW), 3 = edge_capture (read / write-1-to-clear).
- REQ-013: in_port SHALL be sampled into register s1 each clk, then s1 into s2 each clk; data SHALL be s1.
- REQ-014: Per bit, rise = s1 & ~s2, fall = ~s1 & s2; the detect vector SHALL select rise, fall, or rise|fall per EDGE_TYPE.
- REQ-015: A detect bit SHALL set the matching edge_capture bit on the next clk edge; the bit stays set until cleared.
- REQ-016: A write (chipselect=1, write_n=0) to address 3 SHALL clear every edge_capture bit whose writedata bit is 1.
- REQ-017: If set and clear hit the same bit in the same cycle, set SHALL win.
- REQ-018: A write to address 2 SHALL load irq_mask from writedata[WIDTH-1:0] on the next clk edge.
- REQ-019: Writes to addresses 0 and 1 SHALL have no effect.
- REQ-020: readdata SHALL be loaded every clk from the register addressed by address, giving 1-cycle read latency; chipselect does not gate the update.
- REQ-021: irq SHALL equal OR-reduction of (edge_capture & irq_mask), driven from registers only, with no combinational path from inputs.
- REQ-022: Input-to-data latency SHALL be 1 clk (3 clk with REQ-027); input-to-irq latency SHALL be 3 clk (5 clk with REQ-027).
- REQ-023: Pulses shorter than one clk period are not guaranteed to be captured.

Reset
- REQ-024: On reset assertion, s1, s2, irq_mask, edge_capture and readdata SHALL clear to 0 immediately, without waiting for a clk edge; irq SHALL therefore drop to 0.
- REQ-025: After reset release, an in_port bit already high SHALL register as a rising edge on the first samples.
- REQ-026: Reset asserted mid-write SHALL discard the write.

Configuration
- REQ-027: Macro COVID_PIO_IN_SYNC_EN defined: in_port SHALL pass through a 2-flop synchroniser (reset 0) ahead of s1, adding 2 clk latency.
- REQ-028: Macro COVID_PIO_IN_SYNC_EN undefined: in_port SHALL feed s1 directly; all other behaviour is unchanged.

Verification (WIDTH=8, macro undefined unless noted)
- REQ-029: EDGE_TYPE=0; in_port 0x00->0x05, mask 0xFF -> edge_capture=0x05 and irq=1 three clk after the change; read address 0 returns 0x05 one cycle after address is presented.
- REQ-030: EDGE_TYPE=1; in_port 0xFF->0xF0 -> edge_capture=0x0F; the rising transitions 0xF0->0xFF leave edge_capture unchanged.
- REQ-031: edge_capture=0x0F; write 0x03 to address 3 -> reads 0x0C; write 0x0C in the same cycle as a new bit-2 edge -> reads 0x04.
- REQ-032: edge_capture=0x80, mask 0x00 -> irq=0; write mask 0x80 -> irq=1 the following cycle; clear 0x80 -> irq=0.
- REQ-033: Assert reset mid-operation with mask 0xFF and edge_capture 0x3C -> irq, readdata and all registers read 0 with no clk edge; release with in_port=0x01 -> edge_capture=0x01 (EDGE_TYPE=0).
- REQ-034: Macro defined; step in_port 0x00->0xAA -> data reads 0xAA and irq asserts exactly 2 clk later than without the macro.
